// File: rtl/reg_bank_pkg.sv
// Shared constants and types for the parametrised register bank with busy scoreboard.
package reg_bank_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int N_RD_DEF   = 2;

  // Read-port data source; also documents the bypass priority order.
  typedef enum logic [1:0] {
    SRC_STORE = 2'd0,
    SRC_WR0   = 2'd1,
    SRC_WR1   = 2'd2,
    SRC_ZERO  = 2'd3
  } rd_src_e;

  function automatic int nregs(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/reg_bank_scoreboard.sv
// Per-register busy bits with issue-over-completion priority and a running count of busy registers.
module reg_bank_scoreboard
  import reg_bank_pkg::*;
#(
  parameter  int ADDR_W = ADDR_W_DEF,
  localparam int NREGS  = nregs(ADDR_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              clr0_en,
  input  logic [ADDR_W-1:0] clr0_addr,
  input  logic              clr1_en,
  input  logic [ADDR_W-1:0] clr1_addr,
  output logic [NREGS-1:0]  busy,
  output logic [ADDR_W:0]   busy_cnt
);

  logic [NREGS-1:0] busy_nxt;
  logic [ADDR_W:0]  cnt_nxt;
  logic             inc;
  logic             dec0;
  logic             dec1;

  // A register only leaves the count when it was busy, is not re-issued this cycle,
  // and has not already been counted by the other completion port.
  always_comb begin
    busy_nxt = busy;
    if (clr0_en) busy_nxt[clr0_addr] = 1'b0;
    if (clr1_en) busy_nxt[clr1_addr] = 1'b0;
    if (set_en)  busy_nxt[set_addr]  = 1'b1;

    inc  = set_en && !busy[set_addr];
    dec0 = clr0_en && busy[clr0_addr] && !(set_en && (set_addr == clr0_addr));
    dec1 = clr1_en && busy[clr1_addr] && !(set_en && (set_addr == clr1_addr))
           && !(clr0_en && (clr0_addr == clr1_addr));

    cnt_nxt = busy_cnt + (ADDR_W+1)'(inc) - (ADDR_W+1)'(dec0) - (ADDR_W+1)'(dec1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/reg_bank_sb.sv
// Multi-port register bank with two write-back ports, optional same-cycle bypass and a busy scoreboard.
module reg_bank_sb
  import reg_bank_pkg::*;
#(
  parameter  int DATA_W   = DATA_W_DEF,
  parameter  int ADDR_W   = ADDR_W_DEF,
  parameter  int N_RD     = N_RD_DEF,
  parameter  int ZERO_REG = 1,
  parameter  int BYPASS   = 1,
  localparam int NREGS    = nregs(ADDR_W)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_RD*ADDR_W-1:0] rd_addr,
  output logic [N_RD*DATA_W-1:0] rd_data,
  output logic [N_RD-1:0]        rd_busy,
  input  logic                   wr0_en,
  input  logic [ADDR_W-1:0]      wr0_addr,
  input  logic [DATA_W-1:0]      wr0_data,
  input  logic                   wr1_en,
  input  logic [ADDR_W-1:0]      wr1_addr,
  input  logic [DATA_W-1:0]      wr1_data,
  input  logic                   iss_en,
  input  logic [ADDR_W-1:0]      iss_addr,
  output logic [ADDR_W:0]        busy_cnt,
  output logic                   busy_any
);

  logic [DATA_W-1:0] mem [NREGS];
  logic [NREGS-1:0]  busy;
  logic              wr0_ok;
  logic              wr1_ok;
  logic              iss_ok;
  logic              wr0_shadowed;

  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // Reset also suppresses the bypass path so reads settle to zero once storage clears.
  assign wr0_ok       = wr0_en && !reset && !is_zero(wr0_addr);
  assign wr1_ok       = wr1_en && !reset && !is_zero(wr1_addr);
  assign iss_ok       = iss_en && !reset && !is_zero(iss_addr);
  assign wr0_shadowed = wr1_ok && (wr1_addr == wr0_addr);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else begin
      if (wr0_ok && !wr0_shadowed) mem[wr0_addr] <= wr0_data;
      if (wr1_ok)                  mem[wr1_addr] <= wr1_data;
    end
  end

  reg_bank_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk       (clk),
    .reset     (reset),
    .set_en    (iss_ok),
    .set_addr  (iss_addr),
    .clr0_en   (wr0_ok),
    .clr0_addr (wr0_addr),
    .clr1_en   (wr1_ok),
    .clr1_addr (wr1_addr),
    .busy      (busy),
    .busy_cnt  (busy_cnt)
  );

  assign busy_any = (busy_cnt != '0);

  for (genvar k = 0; k < N_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    rd_src_e           src;
    logic [DATA_W-1:0] data;
    logic              bsy;

    assign addr = rd_addr[k*ADDR_W +: ADDR_W];

    always_comb begin
      src = SRC_STORE;
      if (is_zero(addr))                                    src = SRC_ZERO;
      else if ((BYPASS != 0) && wr1_ok && wr1_addr == addr) src = SRC_WR1;
      else if ((BYPASS != 0) && wr0_ok && wr0_addr == addr) src = SRC_WR0;
    end

    // A forwarded result clears the hazard unless a new producer is issued to the same register.
    always_comb begin
      data = mem[addr];
      bsy  = busy[addr];
      case (src)
        SRC_ZERO: begin
          data = '0;
          bsy  = 1'b0;
        end
        SRC_WR1: begin
          data = wr1_data;
          bsy  = (iss_ok && iss_addr == addr) ? busy[addr] : 1'b0;
        end
        SRC_WR0: begin
          data = wr0_data;
          bsy  = (iss_ok && iss_addr == addr) ? busy[addr] : 1'b0;
        end
        default: begin
          data = mem[addr];
          bsy  = busy[addr];
        end
      endcase
    end

    assign rd_data[k*DATA_W +: DATA_W] = data;
    assign rd_busy[k]                  = bsy;
  end

endmodule

// File: tb/tb_reg_bank_sb.sv
// Scoreboard bench for reg_bank_sb: a default instance with bypass and a small non-bypass instance.
module tb_reg_bank_sb;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Per-instance stimulus: index 0 drives dut_a, index 1 drives dut_b.
  int          ra [2][4];
  bit          w0e [2];
  bit          w1e [2];
  bit          ie  [2];
  int          w0a [2];
  int          w1a [2];
  int          ia  [2];
  logic [31:0] w0d [2];
  logic [31:0] w1d [2];

  logic [9:0]  a_rd_addr;
  logic [63:0] a_rd_data;
  logic [1:0]  a_rd_busy;
  logic [5:0]  a_cnt;
  logic        a_any;
  logic [8:0]  b_rd_addr;
  logic [47:0] b_rd_data;
  logic [2:0]  b_rd_busy;
  logic [3:0]  b_cnt;
  logic        b_any;

  assign a_rd_addr = {5'(ra[0][1]), 5'(ra[0][0])};
  assign b_rd_addr = {3'(ra[1][2]), 3'(ra[1][1]), 3'(ra[1][0])};

  reg_bank_sb dut_a (
    .clk(clk), .reset(reset),
    .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_busy(a_rd_busy),
    .wr0_en(w0e[0]), .wr0_addr(5'(w0a[0])), .wr0_data(w0d[0]),
    .wr1_en(w1e[0]), .wr1_addr(5'(w1a[0])), .wr1_data(w1d[0]),
    .iss_en(ie[0]), .iss_addr(5'(ia[0])),
    .busy_cnt(a_cnt), .busy_any(a_any)
  );

  reg_bank_sb #(.DATA_W(16), .ADDR_W(3), .N_RD(3), .ZERO_REG(0), .BYPASS(0)) dut_b (
    .clk(clk), .reset(reset),
    .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
    .wr0_en(w0e[1]), .wr0_addr(3'(w0a[1])), .wr0_data(w0d[1][15:0]),
    .wr1_en(w1e[1]), .wr1_addr(3'(w1a[1])), .wr1_data(w1d[1][15:0]),
    .iss_en(ie[1]), .iss_addr(3'(ia[1])),
    .busy_cnt(b_cnt), .busy_any(b_any)
  );

  function automatic int nrd_of(input int i);   return (i == 0) ? 2 : 3;   endfunction
  function automatic int nregs_of(input int i); return (i == 0) ? 32 : 8;  endfunction
  function automatic bit zr_of(input int i);    return (i == 0);           endfunction
  function automatic bit bp_of(input int i);    return (i == 0);           endfunction
  function automatic logic [31:0] dmask_of(input int i);
    return (i == 0) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
  endfunction

  // Reference model: architectural register contents and the set of pending registers.
  logic [31:0] mem_m  [2][32];
  bit          busy_m [2][32];

  typedef struct packed {
    logic         inst;
    logic [127:0] data;
    logic [3:0]   busy;
    logic [3:0]   bmask;
    logic [5:0]   cnt;
    logic         any;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_vec  = 0;
  int   n_fail = 0;
  bit   track  = 1'b0;

  task automatic checkOutput(input string name, input int port, input logic [31:0] act,
                             input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s port%0d: got %h, expected %h at %0t", name, port, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 2; i++)
      for (int r = 0; r < 32; r++) begin
        mem_m[i][r]  = '0;
        busy_m[i][r] = 1'b0;
      end
  endtask

  function automatic bit dropped(input int i, input int a);
    return zr_of(i) && (a == 0);
  endfunction

  task automatic predict(input int i);
    exp_t        e;
    int          cnt;
    int          a;
    logic [31:0] d;
    bit          b;
    bit          chk;
    bit          h0;
    bit          h1;
    e   = '0;
    cnt = 0;
    e.inst = i[0];
    for (int r = 0; r < nregs_of(i); r++) cnt += int'(busy_m[i][r]);
    e.cnt = 6'(cnt);
    e.any = (cnt != 0);
    for (int k = 0; k < nrd_of(i); k++) begin
      a   = ra[i][k];
      chk = 1'b1;
      if (dropped(i, a)) begin
        d = '0;
        b = 1'b0;
      end else begin
        d  = mem_m[i][a];
        b  = busy_m[i][a];
        h0 = w0e[i] && (w0a[i] == a);
        h1 = w1e[i] && (w1a[i] == a);
        if (bp_of(i) && !reset && (h0 || h1)) begin
          d   = h1 ? w1d[i] : w0d[i];
          b   = 1'b0;
          chk = !(ie[i] && ia[i] == a);
        end
      end
      e.data[k*32 +: 32] = d & dmask_of(i);
      e.busy[k]  = b;
      e.bmask[k] = chk;
    end
    q.push_back(e);
  endtask

  task automatic commit(input int i);
    if (reset) begin
      for (int r = 0; r < 32; r++) begin
        mem_m[i][r]  = '0;
        busy_m[i][r] = 1'b0;
      end
    end else begin
      if (w0e[i] && !dropped(i, w0a[i])) begin
        mem_m[i][w0a[i]]  = w0d[i] & dmask_of(i);
        busy_m[i][w0a[i]] = 1'b0;
      end
      if (w1e[i] && !dropped(i, w1a[i])) begin
        mem_m[i][w1a[i]]  = w1d[i] & dmask_of(i);
        busy_m[i][w1a[i]] = 1'b0;
      end
      if (ie[i] && !dropped(i, ia[i])) busy_m[i][ia[i]] = 1'b1;
    end
  endtask

  task automatic idle();
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 4; k++) ra[i][k] = 0;
      w0e[i] = 0; w1e[i] = 0; ie[i] = 0;
      w0a[i] = 0; w1a[i] = 0; ia[i] = 0;
      w0d[i] = '0; w1d[i] = '0;
    end
  endtask

  // Inputs for this cycle are already driven; record expectations, advance the model, cross the edge.
  task automatic applyStimulus();
    if (track) begin
      predict(0);
      predict(1);
    end
    commit(0);
    commit(1);
    @(posedge clk);
    #1;
  endtask

  function automatic int raddr(input int i);
    return ($urandom_range(0, 1) == 1) ? $urandom_range(0, 7) : $urandom_range(0, nregs_of(i) - 1);
  endfunction

  task automatic randStim();
    reset = ($urandom_range(0, 63) == 0);
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 4; k++) ra[i][k] = raddr(i);
      w0e[i] = ($urandom_range(0, 2) == 0);
      w1e[i] = ($urandom_range(0, 2) == 0);
      ie[i]  = ($urandom_range(0, 1) == 0);
      w0a[i] = raddr(i);
      w1a[i] = raddr(i);
      ia[i]  = raddr(i);
      w0d[i] = $urandom & dmask_of(i);
      w1d[i] = $urandom & dmask_of(i);
    end
  endtask

  always @(negedge clk) begin
    while (q.size() != 0) begin
      mon_e = q.pop_front();
      if (mon_e.inst == 1'b0) begin
        for (int k = 0; k < 2; k++) begin
          checkOutput("a rd_data", k, a_rd_data[k*32 +: 32], mon_e.data[k*32 +: 32]);
          if (mon_e.bmask[k]) checkOutput("a rd_busy", k, 32'(a_rd_busy[k]), 32'(mon_e.busy[k]));
        end
        checkOutput("a busy_cnt", 0, 32'(a_cnt), 32'(mon_e.cnt));
        checkOutput("a busy_any", 0, 32'(a_any), 32'(mon_e.any));
      end else begin
        for (int k = 0; k < 3; k++) begin
          checkOutput("b rd_data", k, 32'(b_rd_data[k*16 +: 16]), mon_e.data[k*32 +: 32]);
          if (mon_e.bmask[k]) checkOutput("b rd_busy", k, 32'(b_rd_busy[k]), 32'(mon_e.busy[k]));
        end
        checkOutput("b busy_cnt", 0, 32'(b_cnt), 32'(mon_e.cnt));
        checkOutput("b busy_any", 0, 32'(b_any), 32'(mon_e.any));
      end
    end
  end

  initial begin
    idle();
    reset = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    model_clear();
    reset = 1'b0;
    track = 1'b1;

    idle(); w0e[0] = 1; w0a[0] = 5; w0d[0] = 32'hDEAD_BEEF;
    applyStimulus();
    idle(); ra[0][0] = 5; ra[0][1] = 5;
    #2;
    checkOutput("r5 read", 0, a_rd_data[31:0], 32'hDEAD_BEEF);
    checkOutput("r5 read", 1, a_rd_data[63:32], 32'hDEAD_BEEF);
    applyStimulus();
    idle(); ra[0][0] = 0;
    #2 checkOutput("r0 read", 0, a_rd_data[31:0], 32'h0);
    applyStimulus();

    idle(); w0e[0] = 1; w0a[0] = 7; w0d[0] = 32'h1111_1111;
    w1e[0] = 1; w1a[0] = 7; w1d[0] = 32'h2222_2222; ra[0][0] = 7;
    #2 checkOutput("r7 bypass", 0, a_rd_data[31:0], 32'h2222_2222);
    applyStimulus();
    idle(); ra[0][0] = 7;
    #2 checkOutput("r7 stored", 0, a_rd_data[31:0], 32'h2222_2222);
    applyStimulus();

    idle(); ie[0] = 1; ia[0] = 3; applyStimulus();
    idle(); ie[0] = 1; ia[0] = 4; applyStimulus();
    idle(); ra[0][0] = 3;
    #2;
    checkOutput("cnt after 2 issues", 0, 32'(a_cnt), 32'd2);
    checkOutput("r3 busy", 0, 32'(a_rd_busy[0]), 32'd1);
    applyStimulus();
    idle(); w0e[0] = 1; w0a[0] = 3; w0d[0] = 32'h0000_0033; applyStimulus();
    idle(); ra[0][0] = 3;
    #2;
    checkOutput("cnt after wb r3", 0, 32'(a_cnt), 32'd1);
    checkOutput("r3 not busy", 0, 32'(a_rd_busy[0]), 32'd0);
    applyStimulus();
    idle(); ie[0] = 1; ia[0] = 4; w1e[0] = 1; w1a[0] = 4; w1d[0] = 32'h0000_0044; applyStimulus();
    idle(); ra[0][0] = 4;
    #2;
    checkOutput("cnt iss+wb r4", 0, 32'(a_cnt), 32'd1);
    checkOutput("r4 still busy", 0, 32'(a_rd_busy[0]), 32'd1);
    applyStimulus();
    idle(); w0e[0] = 1; w0a[0] = 4; w0d[0] = 32'h0000_0045; applyStimulus();

    idle(); ie[0] = 1; ia[0] = 0; w0e[0] = 1; w0a[0] = 0; w0d[0] = 32'hFFFF_FFFF; applyStimulus();
    idle(); ra[0][0] = 0;
    #2;
    checkOutput("cnt after r0 issue", 0, 32'(a_cnt), 32'd0);
    checkOutput("r0 masked", 0, a_rd_data[31:0], 32'h0);
    applyStimulus();

    idle(); ie[0] = 1; ia[0] = 1; applyStimulus();
    idle(); ie[0] = 1; ia[0] = 2; applyStimulus();
    idle(); ie[0] = 1; ia[0] = 9; w0e[0] = 1; w0a[0] = 1; w0d[0] = 32'hA5A5_A5A5; applyStimulus();
    idle(); reset = 1'b1; w1e[0] = 1; w1a[0] = 2; w1d[0] = 32'h1234_5678; applyStimulus();
    reset = 1'b0;
    idle(); ra[0][0] = 1; ra[0][1] = 2;
    #2;
    checkOutput("r1 after reset", 0, a_rd_data[31:0], 32'h0);
    checkOutput("r2 after reset", 1, a_rd_data[63:32], 32'h0);
    checkOutput("cnt after reset", 0, 32'(a_cnt), 32'd0);
    checkOutput("any after reset", 0, 32'(a_any), 32'd0);
    applyStimulus();

    for (int i = 0; i < 8; i++) begin
      idle(); w0e[1] = 1; w0a[1] = i; w0d[1] = 32'h1000 + 32'(i); ra[1][0] = i;
      #2 checkOutput("b old value during write", 0, 32'(b_rd_data[15:0]), 32'h0);
      applyStimulus();
    end
    for (int i = 0; i < 8; i++) begin
      idle(); ra[1][0] = i; ra[1][1] = i; ra[1][2] = i;
      #2 checkOutput("b sweep readback", 2, 32'(b_rd_data[47:32]), 32'h1000 + 32'(i));
      applyStimulus();
    end

    repeat (600) begin
      randStim();
      applyStimulus();
    end
    reset = 1'b0;
    idle();
    applyStimulus();
    @(negedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
